traffic_light: RTL and testbench

- Single-intersection vehicle traffic-light controller: GREEN -> YELLOW -> RED -> GREEN cycle driving three lamp outputs plus a pedestrian-walk output.
- Supports a preferential (longer) green, a yellow-blink attention mode, a forced-red override and a green-time programming (preset) mode.
- Clocked at 2 Hz (one cycle = 0.5 s); sits directly behind the board lamp drivers.

---
 rtl/traffic_light_pkg.sv | 40 ++++
 rtl/traffic_light_timer.sv | 42 ++++
 rtl/traffic_light.sv | 160 ++++++++++++++++
 tb/tb_traffic_light.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg
// Shared definitions for the traffic-light controller: timing constants
// (in seconds, converted to clock cycles), the controller state enum,
// lamp encodings and a seconds-to-cycles helper.
package traffic_light_pkg;

  localparam int CYC_PER_S     = 2;   // clock cycles per second
  localparam int GREEN_S       = 30;  // default green time after reset
  localparam int PREF_EXTRA_S  = 10;  // green extension while preferential
  localparam int YELLOW_S      = 3;
  localparam int RED_S         = 2;
  localparam int PRESET_STEP_S = 10;  // green increment per preset_add edge
  localparam int GREEN_MAX_S   = 90;  // saturation limit of programmed green
  localparam int BLINK_HALF    = 3;   // cycles per on/off half of the blink

  // Holds up to (GREEN_MAX_S + PREF_EXTRA_S) * CYC_PER_S = 200.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    INIT,
    GREEN,
    YELLOW,
    RED,
    BLINK,
    PRESET
  } state_t;

  // Lamp encodings: [2]=green, [1]=yellow, [0]=red.
  localparam logic [2:0] LED_OFF    = 3'b000;
  localparam logic [2:0] LED_GREEN  = 3'b100;
  localparam logic [2:0] LED_YELLOW = 3'b010;
  localparam logic [2:0] LED_RED    = 3'b001;

  // A timed state of T seconds ends when the counter reaches T*CYC_PER_S,
  // so it is visible for T*CYC_PER_S+1 cycles.
  function automatic logic [CNT_W-1:0] sec_to_cyc(input logic [CNT_W-1:0] sec);
    return CNT_W'(int'(sec) * CYC_PER_S);
  endfunction

endpackage

// File: rtl/traffic_light_timer.sv
// traffic_light_timer
// Cycle counter for the timed states. It clears to zero, holds, or counts up
// by one each cycle. 'done' is high once the count has reached 'limit'.
// The compare is >= so that a limit which shrinks mid-state (the preferential
// level dropping during green) still ends the state on the next cycle.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-low reset (count -> 0)
//   clear  in   force count to 0 on the next edge (wins over hold)
//   hold   in   keep the current count
//   limit  in   terminal count for the current state
//   count  out  current count
//   done   out  count >= limit
module traffic_light_timer
  import traffic_light_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (!hold) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign done  = (count_reg >= limit);

endmodule

// File: rtl/traffic_light.sv
// traffic_light
// Single-intersection traffic-light controller running at CYC_PER_S Hz.
// Normal cycle is GREEN -> YELLOW -> RED -> GREEN. On top of that:
// attention gives a yellow blink, force_red holds red, and preset enters a
// programming mode where preset_add edges lengthen the green time.
// Priority every cycle (outside INIT): preset > attention > force_red >
// normal sequencing.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-low reset
//   attention     in   level, yellow-blink mode while high
//   preferential  in   level, green extended by PREF_EXTRA_S while high
//   force_red     in   level, hold RED while high
//   preset        in   level, green-time programming mode while high
//   preset_add    in   rising edge adds PRESET_STEP_S to the programmed green
//   leds          out  [2]=green [1]=yellow [0]=red, one-hot or all off
//   lgreen        out  pedestrian walk lamp, lit exactly while in RED
module traffic_light
  import traffic_light_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       attention,
  input  logic       preferential,
  input  logic       force_red,
  input  logic       preset,
  input  logic       preset_add,
  output logic [2:0] leds,
  output logic       lgreen
);

  localparam logic [CNT_W-1:0] GREEN_S_V   = CNT_W'(GREEN_S);
  localparam logic [CNT_W-1:0] PREF_V      = CNT_W'(PREF_EXTRA_S);
  localparam logic [CNT_W-1:0] STEP_V      = CNT_W'(PRESET_STEP_S);
  localparam logic [CNT_W-1:0] MAX_V       = CNT_W'(GREEN_MAX_S);
  localparam logic [CNT_W-1:0] YELLOW_V    = CNT_W'(YELLOW_S);
  localparam logic [CNT_W-1:0] RED_V       = CNT_W'(RED_S);
  localparam logic [CNT_W-1:0] BLINK_HALF_V = CNT_W'(BLINK_HALF);
  localparam logic [CNT_W-1:0] BLINK_LAST_V = CNT_W'(2 * BLINK_HALF - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] green_prog_reg;   // programmed green, seconds
  logic             add_prev_reg;     // preset_add delayed, for edge detect
  logic             add_edge;
  logic [CNT_W-1:0] green_sec;
  logic [CNT_W-1:0] limit;
  logic             cnt_clear;
  logic             cnt_hold;
  logic [CNT_W-1:0] count;
  logic             done;

  // ---------------------------------------------------------------------
  // State register, preset_add edge detector and programmed green time.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= INIT;
      green_prog_reg <= GREEN_S_V;
      add_prev_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      add_prev_reg <= preset_add;
      if (state_reg == PRESET && add_edge) begin
        // Saturate instead of wrapping past the maximum green.
        if (green_prog_reg >= MAX_V - STEP_V) begin
          green_prog_reg <= MAX_V;
        end else begin
          green_prog_reg <= green_prog_reg + STEP_V;
        end
      end
    end
  end

  assign add_edge  = preset_add & ~add_prev_reg;

  // Green target follows the live preferential level every cycle.
  assign green_sec = green_prog_reg + (preferential ? PREF_V : '0);

  // ---------------------------------------------------------------------
  // Terminal count for the state currently being timed.
  // ---------------------------------------------------------------------
  always_comb begin
    limit = '0;
    unique case (state_reg)
      GREEN:   limit = sec_to_cyc(green_sec);
      YELLOW:  limit = sec_to_cyc(YELLOW_V);
      RED:     limit = sec_to_cyc(RED_V);
      BLINK:   limit = BLINK_LAST_V;
      default: limit = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state and counter control.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (state_reg == INIT) begin
      // Leaving reset always shows one green cycle unless programming.
      state_next = preset ? PRESET : GREEN;
    end else if (preset) begin
      state_next = PRESET;
    end else if (attention) begin
      state_next = BLINK;
    end else if (force_red) begin
      state_next = RED;
    end else begin
      unique case (state_reg)
        PRESET:  state_next = GREEN;
        BLINK:   state_next = RED;
        GREEN:   state_next = done ? YELLOW : GREEN;
        YELLOW:  state_next = done ? RED    : YELLOW;
        RED:     state_next = done ? GREEN  : RED;
        default: state_next = GREEN;
      endcase
    end
  end

  always_comb begin
    cnt_clear = 1'b0;
    cnt_hold  = 1'b0;
    if (state_next != state_reg) begin
      cnt_clear = 1'b1;                 // every timed state starts at zero
    end else if (state_next == RED && force_red) begin
      cnt_clear = 1'b1;                 // forced red: counter pinned at zero
    end else if (state_reg == BLINK && done) begin
      cnt_clear = 1'b1;                 // blink period wraps
    end else if (state_reg == PRESET) begin
      cnt_hold = 1'b1;                  // nothing is timed while programming
    end
  end

  traffic_light_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .hold  (cnt_hold),
    .limit (limit),
    .count (count),
    .done  (done)
  );

  // ---------------------------------------------------------------------
  // Lamp decode from the registered state (and counter phase for blink).
  // ---------------------------------------------------------------------
  always_comb begin
    leds = LED_OFF;
    unique case (state_reg)
      GREEN:   leds = LED_GREEN;
      YELLOW:  leds = LED_YELLOW;
      RED:     leds = LED_RED;
      BLINK:   leds = (count >= BLINK_HALF_V) ? LED_YELLOW : LED_OFF;
      default: leds = LED_OFF;
    endcase
  end

  assign lgreen = (state_reg == RED);

endmodule

// File: tb/tb_traffic_light.sv
// tb_traffic_light
// Self-checking bench for traffic_light. Each test task builds a list of
// input vectors with the lamp pattern expected after the following clock
// edge, computed from phase durations in seconds (T s -> 2*T+1 cycles), then
// applies the list and compares leds/lgreen after each edge.
module tb_traffic_light;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       attention = 1'b0;
  logic       preferential = 1'b0;
  logic       force_red = 1'b0;
  logic       preset = 1'b0;
  logic       preset_add = 1'b0;
  logic [2:0] leds;
  logic       lgreen;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       rst;
    logic       att;
    logic       pref;
    logic       frc;
    logic       pre;
    logic       add;
    logic [2:0] leds;
  } vec_t;

  vec_t vq[$];

  traffic_light dut (
    .clk          (clk),
    .rst          (rst),
    .attention    (attention),
    .preferential (preferential),
    .force_red    (force_red),
    .preset       (preset),
    .preset_add   (preset_add),
    .leds         (leds),
    .lgreen       (lgreen)
  );

  always #5 clk = ~clk;

  // Reference timing, in cycles, from the seconds-based rules.
  function automatic int cyc(input int sec);
    return sec * 2 + 1;
  endfunction

  function automatic int prog_green(input int presses);
    int s;
    s = 30 + 10 * presses;
    if (s > 90) s = 90;
    return s;
  endfunction

  function automatic void push(input logic r, input logic a, input logic p,
                               input logic f, input logic pr, input logic ad,
                               input logic [2:0] l, input int n);
    vec_t v;
    v.rst = r; v.att = a; v.pref = p; v.frc = f; v.pre = pr; v.add = ad;
    v.leds = l;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    rst          = v.rst;
    attention    = v.att;
    preferential = v.pref;
    force_red    = v.frc;
    preset       = v.pre;
    preset_add   = v.add;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vq.delete();
    push(0, 0, 0, 0, 0, 0, 3'b000, 2);
    foreach (vq[i]) begin
      apply(vq[i]);
      n_vec++;
      if (leds !== vq[i].leds || lgreen !== (vq[i].leds == 3'b001)) begin
        n_err++;
        $display("FAIL reset vec %0d: leds=%b lgreen=%b, expected leds=%b lgreen=%b",
                 i, leds, lgreen, vq[i].leds, (vq[i].leds == 3'b001));
      end
    end
  endtask

  task automatic test_default_cycle();
    vq.delete();
    push(0, 0, 0, 0, 0, 0, 3'b000, 1);
    push(1, 0, 0, 0, 0, 0, 3'b100, cyc(30));
    push(1, 0, 0, 0, 0, 0, 3'b010, cyc(3));
    push(1, 0, 0, 0, 0, 0, 3'b001, cyc(2));
    push(1, 0, 0, 0, 0, 0, 3'b100, 3);
    foreach (vq[i]) begin
      apply(vq[i]);
      n_vec++;
      if (leds !== vq[i].leds || lgreen !== (vq[i].leds == 3'b001)) begin
        n_err++;
        $display("FAIL default_cycle vec %0d: leds=%b lgreen=%b, expected leds=%b lgreen=%b",
                 i, leds, lgreen, vq[i].leds, (vq[i].leds == 3'b001));
      end
    end
  endtask

  task automatic test_attention();
    int k;
    int len;
    k   = $urandom_range(1, 40);
    len = $urandom_range(6, 20);
    vq.delete();
    push(0, 0, 0, 0, 0, 0, 3'b000, 1);
    push(1, 0, 0, 0, 0, 0, 3'b100, k);
    for (int i = 0; i < len; i++)
      push(1, 1, 0, 0, 0, 0, (((i / 3) % 2) != 0) ? 3'b010 : 3'b000, 1);
    push(1, 0, 0, 0, 0, 0, 3'b001, cyc(2));
    push(1, 0, 0, 0, 0, 0, 3'b100, 2);
    foreach (vq[i]) begin
      apply(vq[i]);
      n_vec++;
      if (leds !== vq[i].leds || lgreen !== (vq[i].leds == 3'b001)) begin
        n_err++;
        $display("FAIL attention vec %0d: leds=%b lgreen=%b, expected leds=%b lgreen=%b",
                 i, leds, lgreen, vq[i].leds, (vq[i].leds == 3'b001));
      end
    end
  endtask

  task automatic test_preferential();
    vq.delete();
    push(0, 0, 0, 0, 0, 0, 3'b000, 1);
    push(1, 0, 1, 0, 0, 0, 3'b100, cyc(30 + 10));
    push(1, 0, 1, 0, 0, 0, 3'b010, cyc(3));
    push(1, 0, 1, 0, 0, 0, 3'b001, cyc(2));
    push(1, 0, 1, 0, 0, 0, 3'b100, 2);
    foreach (vq[i]) begin
      apply(vq[i]);
      n_vec++;
      if (leds !== vq[i].leds || lgreen !== (vq[i].leds == 3'b001)) begin
        n_err++;
        $display("FAIL preferential vec %0d: leds=%b lgreen=%b, expected leds=%b lgreen=%b",
                 i, leds, lgreen, vq[i].leds, (vq[i].leds == 3'b001));
      end
    end
  endtask

  task automatic test_preset();
    logic [4:0] pat;
    pat = 5'b01011;   // applied LSB first: 1,1,0,1,0 -> two rising edges
    vq.delete();
    push(0, 0, 0, 0, 1, 0, 3'b000, 1);
    push(1, 0, 0, 0, 1, 0, 3'b000, 1);
    for (int i = 0; i < 5; i++) push(1, 0, 0, 0, 1, pat[i], 3'b000, 1);
    push(1, 0, 0, 0, 0, 0, 3'b100, cyc(50));
    push(1, 0, 0, 0, 0, 0, 3'b010, cyc(3));
    push(1, 0, 0, 0, 0, 0, 3'b001, cyc(2));
    push(1, 0, 0, 0, 0, 0, 3'b100, 2);
    foreach (vq[i]) begin
      apply(vq[i]);
      n_vec++;
      if (leds !== vq[i].leds || lgreen !== (vq[i].leds == 3'b001)) begin
        n_err++;
        $display("FAIL preset vec %0d: leds=%b lgreen=%b, expected leds=%b lgreen=%b",
                 i, leds, lgreen, vq[i].leds, (vq[i].leds == 3'b001));
      end
    end
  endtask

  task automatic test_force_red();
    int hold;
    hold = $urandom_range(3, 30);
    vq.delete();
    push(0, 0, 0, 1, 0, 0, 3'b000, 1);
    push(1, 0, 0, 1, 0, 0, 3'b100, 1);      // first cycle out of reset is green
    push(1, 0, 0, 1, 0, 0, 3'b001, hold);
    // The cycle in which force_red falls is already the first of the five
    // red cycles, so four more are seen after the next edges.
    push(1, 0, 0, 0, 0, 0, 3'b001, cyc(2) - 1);
    push(1, 0, 0, 0, 0, 0, 3'b100, 2);
    foreach (vq[i]) begin
      apply(vq[i]);
      n_vec++;
      if (leds !== vq[i].leds || lgreen !== (vq[i].leds == 3'b001)) begin
        n_err++;
        $display("FAIL force_red vec %0d: leds=%b lgreen=%b, expected leds=%b lgreen=%b",
                 i, leds, lgreen, vq[i].leds, (vq[i].leds == 3'b001));
      end
    end
  endtask

  task automatic test_saturation_and_mid_reset();
    int k;
    k = $urandom_range(1, 50);
    vq.delete();
    push(0, 0, 0, 0, 1, 0, 3'b000, 1);
    push(1, 0, 0, 0, 1, 0, 3'b000, 1);
    for (int i = 0; i < 8; i++) begin
      push(1, 0, 0, 0, 1, 1, 3'b000, 1);
      push(1, 0, 0, 0, 1, 0, 3'b000, 1);
    end
    push(1, 0, 0, 0, 0, 0, 3'b100, cyc(prog_green(8)));
    push(1, 0, 0, 0, 0, 0, 3'b010, cyc(3));
    push(1, 0, 0, 0, 0, 0, 3'b001, cyc(2));
    push(1, 0, 0, 0, 0, 0, 3'b100, k);
    push(0, 0, 0, 0, 0, 0, 3'b000, 1);      // reset in the middle of green
    push(1, 0, 0, 0, 0, 0, 3'b100, cyc(30)); // programmed green back to default
    push(1, 0, 0, 0, 0, 0, 3'b010, 1);
    foreach (vq[i]) begin
      apply(vq[i]);
      n_vec++;
      if (leds !== vq[i].leds || lgreen !== (vq[i].leds == 3'b001)) begin
        n_err++;
        $display("FAIL saturation_mid_reset vec %0d: leds=%b lgreen=%b, expected leds=%b lgreen=%b",
                 i, leds, lgreen, vq[i].leds, (vq[i].leds == 3'b001));
      end
    end
  endtask

  task automatic test_random_program();
    int   n;
    logic p;
    n = $urandom_range(0, 10);
    p = 1'($urandom_range(0, 1));
    vq.delete();
    push(0, 0, p, 0, 1, 0, 3'b000, 1);
    push(1, 0, p, 0, 1, 0, 3'b000, 1);
    for (int i = 0; i < n; i++) begin
      push(1, 0, p, 0, 1, 1, 3'b000, 1);
      push(1, 0, p, 0, 1, 0, 3'b000, 1);
    end
    push(1, 0, p, 0, 0, 0, 3'b100, cyc(prog_green(n) + (p ? 10 : 0)));
    push(1, 0, p, 0, 0, 0, 3'b010, cyc(3));
    push(1, 0, p, 0, 0, 0, 3'b001, cyc(2));
    push(1, 0, p, 0, 0, 0, 3'b100, 1);
    foreach (vq[i]) begin
      apply(vq[i]);
      n_vec++;
      if (leds !== vq[i].leds || lgreen !== (vq[i].leds == 3'b001)) begin
        n_err++;
        $display("FAIL random_program(n=%0d pref=%0d) vec %0d: leds=%b lgreen=%b, expected leds=%b lgreen=%b",
                 n, p, i, leds, lgreen, vq[i].leds, (vq[i].leds == 3'b001));
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_cycle();
    test_attention();
    test_preferential();
    test_preset();
    test_force_red();
    test_saturation_and_mid_reset();
    for (int r = 0; r < 3; r++) test_random_program();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
